// File: rtl/keyboard_pkg.sv
// Shared types and keycode map for the polyphonic keyboard voice allocator.
package keyboard_pkg;

    typedef logic [2:0] note_t;
    typedef logic [2:0] octave_t;

    typedef struct packed {
        logic       valid;
        logic       is_instr;
        logic [3:0] instr_idx;
        note_t      note;
        octave_t    octave;
        logic       flat;
    } key_info_t;

    localparam logic [7:0] KC_NONE = 8'h00;
    localparam logic [7:0] KC_F1   = 8'h3a;
    localparam logic [7:0] KC_F12  = 8'h45;
    localparam logic [7:0] KC_C4   = 8'h30;

    function automatic key_info_t note_key(input note_t n, input octave_t o, input logic f);
        key_info_t ki;
        ki        = '0;
        ki.valid  = 1'b1;
        ki.note   = n;
        ki.octave = o;
        ki.flat   = f;
        return ki;
    endfunction

    function automatic key_info_t keycode_lookup(input logic [7:0] kc);
        key_info_t ki;
        ki = '0;
        case (kc)
            8'h1d: ki = note_key(3'd1, 3'd1, 1'b0);
            8'h1b: ki = note_key(3'd2, 3'd1, 1'b0);
            8'h06: ki = note_key(3'd3, 3'd1, 1'b0);
            8'h19: ki = note_key(3'd4, 3'd1, 1'b0);
            8'h05: ki = note_key(3'd5, 3'd1, 1'b0);
            8'h11: ki = note_key(3'd6, 3'd1, 1'b0);
            8'h10: ki = note_key(3'd7, 3'd1, 1'b0);
            8'h16: ki = note_key(3'd2, 3'd1, 1'b1);
            8'h07: ki = note_key(3'd3, 3'd1, 1'b1);
            8'h0a: ki = note_key(3'd5, 3'd1, 1'b1);
            8'h0b: ki = note_key(3'd6, 3'd1, 1'b1);
            8'h0d: ki = note_key(3'd7, 3'd1, 1'b1);
            8'h36: ki = note_key(3'd1, 3'd2, 1'b0);
            8'h37: ki = note_key(3'd2, 3'd2, 1'b0);
            8'h38: ki = note_key(3'd3, 3'd2, 1'b0);
            8'h14: ki = note_key(3'd4, 3'd2, 1'b0);
            8'h1a: ki = note_key(3'd5, 3'd2, 1'b0);
            8'h08: ki = note_key(3'd6, 3'd2, 1'b0);
            8'h15: ki = note_key(3'd7, 3'd2, 1'b0);
            8'h0f: ki = note_key(3'd2, 3'd2, 1'b1);
            8'h33: ki = note_key(3'd3, 3'd2, 1'b1);
            8'h1f: ki = note_key(3'd5, 3'd2, 1'b1);
            8'h20: ki = note_key(3'd6, 3'd2, 1'b1);
            8'h21: ki = note_key(3'd7, 3'd2, 1'b1);
            8'h17: ki = note_key(3'd1, 3'd3, 1'b0);
            8'h1c: ki = note_key(3'd2, 3'd3, 1'b0);
            8'h18: ki = note_key(3'd3, 3'd3, 1'b0);
            8'h0c: ki = note_key(3'd4, 3'd3, 1'b0);
            8'h12: ki = note_key(3'd5, 3'd3, 1'b0);
            8'h13: ki = note_key(3'd6, 3'd3, 1'b0);
            8'h2f: ki = note_key(3'd7, 3'd3, 1'b0);
            8'h23: ki = note_key(3'd2, 3'd3, 1'b1);
            8'h24: ki = note_key(3'd3, 3'd3, 1'b1);
            8'h26: ki = note_key(3'd5, 3'd3, 1'b1);
            8'h27: ki = note_key(3'd6, 3'd3, 1'b1);
            8'h2d: ki = note_key(3'd7, 3'd3, 1'b1);
            KC_C4: ki = note_key(3'd1, 3'd4, 1'b0);
            default: begin
                // Function keys F1..F12 report their index; the allocator filters by instrument count.
                if (kc >= KC_F1 && kc <= KC_F12) begin
                    ki.valid     = 1'b1;
                    ki.is_instr  = 1'b1;
                    ki.instr_idx = 4'(kc - KC_F1);
                end
            end
        endcase
        return ki;
    endfunction

endpackage

// File: rtl/keycode_note_map.sv
// Combinational keycode decoder wrapping keyboard_pkg::keycode_lookup.
module keycode_note_map
    import keyboard_pkg::*;
(
    input  logic [7:0] keycode,
    output key_info_t  info
);

    assign info = keycode_lookup(keycode);

endmodule

// File: rtl/keyboard_voice_alloc.sv
// Polyphonic HID-report voice allocator: release scan then assign scan per report.
// Optional VOICE_STEAL_EN: overwrite the oldest voice instead of dropping the key.
module keyboard_voice_alloc
    import keyboard_pkg::*;
#(
    parameter int NUM_KEYS   = 6,
    parameter int NUM_VOICES = 4,
    parameter int NUM_INSTR  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         report_valid,
    output logic                         report_ready,
    input  logic [8*NUM_KEYS-1:0]        keycodes,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [3*NUM_VOICES-1:0]      voice_note,
    output logic [3*NUM_VOICES-1:0]      voice_octave,
    output logic [NUM_VOICES-1:0]        voice_flat,
    output logic [NUM_VOICES-1:0]        voice_trig,
    output logic [((NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1)-1:0] instrument,
    output logic                         drop
);

    localparam int IW   = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1;
    localparam int VW   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int MAXN = (NUM_KEYS > NUM_VOICES) ? NUM_KEYS : NUM_VOICES;
    localparam int XW   = (MAXN > 1) ? $clog2(MAXN) : 1;

    typedef enum logic [1:0] {IDLE, RELEASE, ASSIGN} state_t;

    state_t        state;
    logic [XW-1:0] idx;
    logic [7:0]    report_q [NUM_KEYS];
    logic [7:0]    voice_kc [NUM_VOICES];
    logic [7:0]    cur_kc, rel_kc;
    logic          rel_act, rel_present, held, free_found;
    logic          accept, is_note, do_assign, do_drop;
    logic [VW-1:0] free_v, tgt_v;
    key_info_t     info;

    keycode_note_map u_map (
        .keycode (cur_kc),
        .info    (info)
    );

    assign accept  = report_valid && report_ready;
    assign is_note = (state == ASSIGN) && info.valid && !info.is_instr;

    always_comb begin
        cur_kc      = '0;
        rel_kc      = '0;
        rel_act     = 1'b0;
        rel_present = 1'b0;
        held        = 1'b0;
        free_found  = 1'b0;
        free_v      = '0;
        for (int unsigned k = 0; k < NUM_KEYS; k++)
            if (idx == XW'(k)) cur_kc = report_q[k];
        for (int unsigned v = 0; v < NUM_VOICES; v++)
            if (idx == XW'(v)) begin
                rel_kc  = voice_kc[v];
                rel_act = voice_active[v];
            end
        for (int unsigned k = 0; k < NUM_KEYS; k++)
            if (report_q[k] == rel_kc) rel_present = 1'b1;
        for (int unsigned v = 0; v < NUM_VOICES; v++)
            if (voice_active[v] && voice_kc[v] == cur_kc) held = 1'b1;
        // Descending scan so the lowest free index is the last one written.
        for (int unsigned v = NUM_VOICES; v > 0; v--)
            if (!voice_active[v-1]) begin
                free_found = 1'b1;
                free_v     = VW'(v - 1);
            end
    end

`ifdef VOICE_STEAL_EN
    logic [7:0]    age [NUM_VOICES];
    logic [7:0]    oldest_age;
    logic [VW-1:0] old_v;

    always_comb begin
        old_v      = '0;
        oldest_age = age[0];
        for (int unsigned v = 1; v < NUM_VOICES; v++)
            if (age[v] > oldest_age) begin
                oldest_age = age[v];
                old_v      = VW'(v);
            end
    end

    assign tgt_v     = free_found ? free_v : old_v;
    assign do_assign = is_note && !held;
    assign do_drop   = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) age[v] <= '0;
        end else begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                if (do_assign && tgt_v == VW'(v))
                    age[v] <= '0;
                else if (accept && voice_active[v] && age[v] != 8'hff)
                    age[v] <= age[v] + 8'd1;
            end
        end
    end
`else
    assign tgt_v     = free_v;
    assign do_assign = is_note && !held && free_found;
    assign do_drop   = is_note && !held && !free_found;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            report_ready <= 1'b1;
            voice_active <= '0;
            voice_note   <= '0;
            voice_octave <= '0;
            voice_flat   <= '0;
            voice_trig   <= '0;
            instrument   <= '0;
            drop         <= 1'b0;
            for (int unsigned k = 0; k < NUM_KEYS; k++) report_q[k] <= '0;
            for (int unsigned v = 0; v < NUM_VOICES; v++) voice_kc[v] <= '0;
        end else begin
            voice_trig <= '0;
            drop       <= do_drop;
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int unsigned k = 0; k < NUM_KEYS; k++)
                            report_q[k] <= keycodes[8*k +: 8];
                        state        <= RELEASE;
                        idx          <= '0;
                        report_ready <= 1'b0;
                    end
                end
                RELEASE: begin
                    for (int unsigned v = 0; v < NUM_VOICES; v++)
                        if (idx == XW'(v) && rel_act && !rel_present) begin
                            voice_active[v] <= 1'b0;
                            voice_kc[v]     <= '0;
                        end
                    if (idx == XW'(NUM_VOICES - 1)) begin
                        state <= ASSIGN;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ASSIGN: begin
                    if (info.valid && info.is_instr && int'(info.instr_idx) < NUM_INSTR)
                        instrument <= IW'(info.instr_idx);
                    for (int unsigned v = 0; v < NUM_VOICES; v++)
                        if (do_assign && tgt_v == VW'(v)) begin
                            voice_active[v]       <= 1'b1;
                            voice_kc[v]           <= cur_kc;
                            voice_note[3*v +: 3]   <= info.note;
                            voice_octave[3*v +: 3] <= info.octave;
                            voice_flat[v]         <= info.flat;
                            voice_trig[v]         <= 1'b1;
                        end
                    if (idx == XW'(NUM_KEYS - 1)) begin
                        state        <= IDLE;
                        idx          <= '0;
                        report_ready <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
